// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder: access-size codes,
// control FSM states, the latched request record and the alignment rule.
package dmem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } dmem_state_e;

    typedef struct packed {
        logic [31:0] addr;
        logic        wren;
        logic [1:0]  size;
        logic        ld_unsigned;
        logic [31:0] st_data;
    } dmem_req_t;

    // Size code 2'b11 falls into the word rule.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        logic mis;
        case (size)
            SZ_BYTE: mis = 1'b0;
            SZ_HALF: mis = addr_lo[0];
            default: mis = |addr_lo;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane steering: extracts and extends load data from a stored
// word, and merges right-justified store data into the addressed byte lanes.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [31:0] rd_word,
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic        ld_unsigned,
    input  logic [31:0] st_data,
    output logic [31:0] ld_data,
    output logic [31:0] wr_word
);

    logic signed [7:0]  byte_lane;
    logic signed [15:0] half_lane;
    logic signed [31:0] byte_sext;
    logic signed [31:0] half_sext;

    assign byte_lane = rd_word[{addr_lo, 3'b000} +: 8];
    assign half_lane = rd_word[{addr_lo[1], 4'b0000} +: 16];
    assign byte_sext = 32'(byte_lane);
    assign half_sext = 32'(half_lane);

    always_comb begin
        ld_data = rd_word;
        case (size)
            SZ_BYTE: ld_data = ld_unsigned ? {24'd0, byte_lane} : byte_sext;
            SZ_HALF: ld_data = ld_unsigned ? {16'd0, half_lane} : half_sext;
            default: ld_data = rd_word;
        endcase
    end

    always_comb begin
        wr_word = rd_word;
        case (size)
            SZ_BYTE: wr_word[{addr_lo, 3'b000} +: 8]     = st_data[7:0];
            SZ_HALF: wr_word[{addr_lo[1], 4'b0000} +: 16] = st_data[15:0];
            default: wr_word = st_data;
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory target for the pipeline load/store port: one request at a time,
// WAIT_STATES wait cycles, registered one-cycle response.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int          DEPTH_WORDS = 2048,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_2000,
    parameter int          WAIT_STATES = 1,
    parameter string       INIT_FILE   = "dmem.hex"
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    input  logic        i_wren,
    input  logic [1:0]  i_size,
    input  logic        i_unsigned,
    input  logic [31:0] i_st_data,
    output logic        o_ready,
    output logic [31:0] o_ld_data,
    output logic        o_misalign
);

    localparam int          IDX_W      = $clog2(DEPTH_WORDS);
    localparam int          SPAN_W     = IDX_W + 2;
    localparam logic [32:0] SPAN_BYTES = 33'(DEPTH_WORDS) << 2;
    localparam logic [3:0]  CNT_LOAD   = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    logic [31:0] mem [DEPTH_WORDS];

    dmem_state_e state, state_d;
    logic [3:0]  cnt, cnt_d;
    dmem_req_t   req_p0, cur_req;
    logic        latch;
    logic        enter_resp;
    logic        ready_d, mis_d, mem_we;
    logic [31:0] ld_d;

    logic [31:0]      offset;
    logic             in_range;
    logic             misalign;
    logic [IDX_W-1:0] word_idx;
    logic [31:0]      rd_word, ld_word, wr_word;

    // With zero wait states the response is built on the accepting edge, so
    // the live request fields stand in for the not-yet-latched copy.
    always_comb begin
        cur_req = req_p0;
        if (state == IDLE) begin
            cur_req = '{addr: i_addr, wren: i_wren, size: i_size,
                        ld_unsigned: i_unsigned, st_data: i_st_data};
        end
    end

    assign offset   = cur_req.addr - BASE_ADDR;
    assign in_range = {1'b0, offset} < SPAN_BYTES;
    assign word_idx = offset[SPAN_W-1:2];
    assign misalign = is_misaligned(cur_req.size, cur_req.addr[1:0]);
    assign rd_word  = mem[word_idx];

    dmem_lane_align u_lane_align (
        .rd_word     (rd_word),
        .addr_lo     (cur_req.addr[1:0]),
        .size        (cur_req.size),
        .ld_unsigned (cur_req.ld_unsigned),
        .st_data     (cur_req.st_data),
        .ld_data     (ld_word),
        .wr_word     (wr_word)
    );

    always_comb begin
        state_d    = state;
        cnt_d      = cnt;
        latch      = 1'b0;
        enter_resp = 1'b0;
        ready_d    = 1'b0;
        mis_d      = 1'b0;
        ld_d       = 32'd0;
        mem_we     = 1'b0;
        case (state)
            IDLE: begin
                if (i_req) begin
                    latch = 1'b1;
                    if (WAIT_STATES == 0) begin
                        state_d    = RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_LOAD;
                    end
                end
            end
            WAIT: begin
                if (cnt == 4'd0) begin
                    state_d    = RESP;
                    enter_resp = 1'b1;
                end else begin
                    cnt_d = cnt - 4'd1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (enter_resp) begin
            ready_d = 1'b1;
            mis_d   = misalign;
            if (!misalign && in_range) begin
                if (cur_req.wren) mem_we = 1'b1;
                else              ld_d   = ld_word;
            end
        end
    end

    // Control, latched request and registered response
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            req_p0     <= '0;
            o_ready    <= 1'b0;
            o_ld_data  <= 32'd0;
            o_misalign <= 1'b0;
        end else begin
            state      <= state_d;
            cnt        <= cnt_d;
            if (latch) req_p0 <= cur_req;
            o_ready    <= ready_d;
            o_ld_data  <= ld_d;
            o_misalign <= mis_d;
        end
    end

    // Store commit; a reset held across the edge cancels it
    always_ff @(posedge i_clk) begin
        if (mem_we && !i_rst) mem[word_idx] <= wr_word;
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: one instance with one wait state, one
// with none, driven from a vector table plus hand-written corner sequences.
module tb_dmem_responder;

    localparam logic [1:0] B  = 2'b00;
    localparam logic [1:0] H  = 2'b01;
    localparam logic [1:0] W  = 2'b10;
    localparam logic [1:0] W3 = 2'b11;
    localparam int NV = 29;

    typedef struct {
        bit          sel;
        logic        wren;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_ld;
        logic        exp_mis;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic        req1 = 0, wren1 = 0, uns1 = 0;
    logic [1:0]  size1 = 0;
    logic [31:0] addr1 = 0, data1 = 0;
    logic        rdy1, mis1;
    logic [31:0] ld1;

    logic        req0 = 0, wren0 = 0, uns0 = 0;
    logic [1:0]  size0 = 0;
    logic [31:0] addr0 = 0, data0 = 0;
    logic        rdy0, mis0;
    logic [31:0] ld0;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH_WORDS(2048), .BASE_ADDR(32'h2000), .WAIT_STATES(1)) u_dut1 (
        .i_clk(clk), .i_rst(rst), .i_req(req1), .i_addr(addr1), .i_wren(wren1),
        .i_size(size1), .i_unsigned(uns1), .i_st_data(data1),
        .o_ready(rdy1), .o_ld_data(ld1), .o_misalign(mis1)
    );

    dmem_responder #(.DEPTH_WORDS(2048), .BASE_ADDR(32'h2000), .WAIT_STATES(0)) u_dut0 (
        .i_clk(clk), .i_rst(rst), .i_req(req0), .i_addr(addr0), .i_wren(wren0),
        .i_size(size0), .i_unsigned(uns0), .i_st_data(data0),
        .o_ready(rdy0), .o_ld_data(ld0), .o_misalign(mis0)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic run_req(input vec_t v, input string nm);
        int  n;
        bit  got;
        logic r, m;
        logic [31:0] d;
        @(negedge clk);
        if (v.sel) begin
            wren1 = v.wren; size1 = v.size; uns1 = v.uns; addr1 = v.addr; data1 = v.wdata; req1 = 1;
        end else begin
            wren0 = v.wren; size0 = v.size; uns0 = v.uns; addr0 = v.addr; data0 = v.wdata; req0 = 1;
        end
        n = 0;
        got = 0;
        while (!got && n < 40) begin
            @(posedge clk);
            #1;
            n++;
            r = v.sel ? rdy1 : rdy0;
            if (r) got = 1;
        end
        if (!got) begin
            check({nm, " timeout"}, 32'(n), 32'(v.sel ? 2 : 1));
        end else begin
            d = v.sel ? ld1 : ld0;
            m = v.sel ? mis1 : mis0;
            check({nm, " latency"}, 32'(n), 32'(v.sel ? 2 : 1));
            check({nm, " ld_data"}, d, v.exp_ld);
            check({nm, " misalign"}, 32'(m), 32'(v.exp_mis));
        end
        @(negedge clk);
        req1 = 0;
        req0 = 0;
        @(posedge clk);
        #1;
        r = v.sel ? rdy1 : rdy0;
        d = v.sel ? ld1 : ld0;
        check({nm, " pulse end"}, {r, d[30:0]}, 32'd0);
    endtask

    vec_t vecs [NV];
    vec_t hv;

    initial begin
        vecs = '{
            '{1, 1, W,  0, 32'h2010, 32'hDEADBEEF, 32'h0,        0},
            '{1, 0, W,  0, 32'h2010, 32'h0,        32'hDEADBEEF, 0},
            '{1, 0, B,  0, 32'h2013, 32'h0,        32'hFFFFFFDE, 0},
            '{1, 0, B,  1, 32'h2013, 32'h0,        32'h000000DE, 0},
            '{1, 0, H,  0, 32'h2010, 32'h0,        32'hFFFFBEEF, 0},
            '{1, 0, H,  1, 32'h2012, 32'h0,        32'h0000DEAD, 0},
            '{1, 1, B,  0, 32'h2011, 32'hAAAAAA55, 32'h0,        0},
            '{1, 0, W,  1, 32'h2010, 32'h0,        32'hDEAD55EF, 0},
            '{1, 1, W,  0, 32'h2020, 32'h01234567, 32'h0,        0},
            '{1, 1, W,  0, 32'h2022, 32'hFFFFFFFF, 32'h0,        1},
            '{1, 0, W,  0, 32'h2020, 32'h0,        32'h01234567, 0},
            '{1, 0, H,  0, 32'h2021, 32'h0,        32'h0,        1},
            '{1, 1, H,  0, 32'h2022, 32'h11119876, 32'h0,        0},
            '{1, 0, W,  0, 32'h2020, 32'h0,        32'h98764567, 0},
            '{1, 0, B,  0, 32'h2021, 32'h0,        32'h00000045, 0},
            '{1, 0, H,  0, 32'h2022, 32'h0,        32'hFFFF9876, 0},
            '{1, 1, W3, 0, 32'h2030, 32'hA5A50F0F, 32'h0,        0},
            '{1, 0, W3, 0, 32'h2030, 32'h0,        32'hA5A50F0F, 0},
            '{1, 1, W,  0, 32'h4010, 32'h77777777, 32'h0,        0},
            '{1, 0, W,  0, 32'h4010, 32'h0,        32'h0,        0},
            '{1, 0, W,  0, 32'h2010, 32'h0,        32'hDEAD55EF, 0},
            '{1, 0, W3, 0, 32'h2031, 32'h0,        32'h0,        1},
            '{0, 0, W,  0, 32'h1FFC, 32'h0,        32'h0,        0},
            '{0, 1, H,  0, 32'h2050, 32'h0000C3A7, 32'h0,        0},
            '{0, 0, H,  1, 32'h2050, 32'h0,        32'h0000C3A7, 0},
            '{0, 0, H,  0, 32'h2050, 32'h0,        32'hFFFFC3A7, 0},
            '{0, 1, B,  0, 32'h2052, 32'h00000080, 32'h0,        0},
            '{0, 0, B,  0, 32'h2052, 32'h0,        32'hFFFFFF80, 0},
            '{0, 0, B,  1, 32'h2052, 32'h0,        32'h00000080, 0}
        };

        repeat (3) @(posedge clk);
        #1;
        check("reset ready", {31'd0, rdy1} | {31'd0, rdy0}, 32'd0);
        check("reset ld_data", ld1 | ld0, 32'd0);
        check("reset misalign", {31'd0, mis1} | {31'd0, mis0}, 32'd0);
        @(negedge clk);
        rst = 0;

        for (int i = 0; i < NV; i++) begin
            run_req(vecs[i], $sformatf("vec%0d", i));
        end

        // Back-to-back stores on the zero-wait instance with i_req held high
        @(negedge clk);
        wren0 = 1; size0 = W; uns0 = 0; addr0 = 32'h2100; data0 = 32'h10000000; req0 = 1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("b2b ready cyc%0d", i), {31'd0, rdy0}, {31'd0, (i % 2) == 0});
            if (rdy0) begin
                addr0 = addr0 + 32'd4;
                data0 = data0 + 32'd1;
            end
        end
        @(negedge clk);
        req0 = 0;
        hv = '{0, 0, W, 0, 32'h2104, 32'h0, 32'h10000001, 0};
        run_req(hv, "b2b word1");
        hv = '{0, 0, W, 0, 32'h210C, 32'h0, 32'h10000003, 0};
        run_req(hv, "b2b word3");

        // Reset while a store sits in WAIT must cancel it
        hv = '{1, 1, W, 0, 32'h2040, 32'hCAFEF00D, 32'h0, 0};
        run_req(hv, "rst prestore");
        @(negedge clk);
        wren1 = 1; size1 = W; uns1 = 0; addr1 = 32'h2040; data1 = 32'h12345678; req1 = 1;
        @(posedge clk);
        #1;
        rst = 1;
        #1;
        check("rst mid ready", {31'd0, rdy1}, 32'd0);
        @(negedge clk);
        req1 = 0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("rst hold ready%0d", i), {31'd0, rdy1}, 32'd0);
        end
        @(negedge clk);
        rst = 0;
        hv = '{1, 0, W, 0, 32'h2040, 32'h0, 32'hCAFEF00D, 0};
        run_req(hv, "rst reload");

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
        $finish;
    end

endmodule
